// File: rtl/eth_rx_stat_pkg.sv
// Shared definitions for the MAC rx status tracking slice: default widths,
// the default error mask and the completed-packet report record.
package eth_rx_stat_pkg;

  localparam int STAT_W_DEF  = 26;
  localparam int FCS_ERR_BIT = 17;

  localparam logic [STAT_W_DEF-1:0] ERR_MASK_DEF = STAT_W_DEF'(1) << FCS_ERR_BIT;

  // Per-packet result as seen by the rx parser
  typedef struct packed {
    logic [STAT_W_DEF-1:0] statvec;
    logic                  err;
    logic                  miss;
  } pktReport_t;

endpackage

// File: rtl/eth_stat_fifo.sv
// Generic DEPTH x WIDTH register FIFO with occupancy output; a push while full
// is accepted only when a pop happens in the same cycle.
module eth_stat_fifo
  import eth_rx_stat_pkg::*;
#(
  parameter int WIDTH = STAT_W_DEF,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] headData_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             doPush;
  logic             doPop;

  assign full_o     = (level_q == LVL_W'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;
  assign headData_o = mem_q[rdPtr_q];

  assign doPush = push_i & (~full_o | pop_i);
  assign doPop  = pop_i & ~empty_o;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
    if (doPush && !doPop)      level_d = level_q + LVL_W'(1);
    else if (doPop && !doPush) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  // Storage carries no reset; entries are only read while the level says valid
  always_ff @(posedge clock_i) begin
    if (doPush) mem_q[wrPtr_q] <= pushData_i;
  end

endmodule

// File: rtl/eth_rx_pkt_stat_q.sv
// Pairs queued MAC rx status vectors, in order, with AXIS rx packets as they
// complete, and reports per-packet errors, FIFO health and statistics.
module eth_rx_pkt_stat_q
  import eth_rx_stat_pkg::*;
#(
  parameter int              STAT_W   = STAT_W_DEF,
  parameter int              DEPTH    = 4,
  parameter logic [STAT_W-1:0] ERR_MASK = STAT_W'(ERR_MASK_DEF),
  parameter int              CNT_W    = 32,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic              i_pclk,
  input  logic              i_prst,
  input  logic              i_mac_rx_staten,
  input  logic [STAT_W-1:0] i_mac_rx_statvec,
  input  logic              i_axis_rx_tvalid,
  input  logic              i_axis_rx_tready,
  input  logic              i_axis_rx_tlast,
  input  logic              i_cnt_clr,
  output logic              o_head_known,
  output logic              o_head_err,
  output logic              o_pkt_stat_vld,
  output logic [STAT_W-1:0] o_pkt_statvec,
  output logic              o_pkt_err,
  output logic              o_pkt_stat_miss,
  output logic [LVL_W-1:0]  o_q_level,
  output logic              o_q_ovf,
  output logic              o_q_unf,
  output logic [CNT_W-1:0]  o_pkt_cnt,
  output logic [CNT_W-1:0]  o_err_cnt
);

  logic              staten_q;
  logic              enq;
  logic              deq;
  logic              fifoPush;
  logic              fifoPop;
  logic [STAT_W-1:0] fifoHead;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [STAT_W-1:0] headVec;

  logic              pktVld_q, pktVld_d;
  logic [STAT_W-1:0] pktStatvec_q, pktStatvec_d;
  logic              pktErr_q, pktErr_d;
  logic              pktMiss_q, pktMiss_d;
  logic              qOvf_q, qOvf_d;
  logic              qUnf_q, qUnf_d;
  logic [CNT_W-1:0]  pktCnt_q, pktCnt_d;
  logic [CNT_W-1:0]  errCnt_q, errCnt_d;

  assign enq = i_mac_rx_staten & ~staten_q;
  assign deq = i_axis_rx_tvalid & i_axis_rx_tready & i_axis_rx_tlast;

  // An empty FIFO hit by enq and deq together hands the new status straight
  // to the ending packet, so nothing is stored
  assign fifoPush = enq & ~(fifoEmpty & deq);
  assign fifoPop  = deq & ~fifoEmpty;

  eth_stat_fifo #(
    .WIDTH (STAT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock_i    (i_pclk),
    .reset_i    (i_prst),
    .push_i     (fifoPush),
    .pushData_i (i_mac_rx_statvec),
    .pop_i      (fifoPop),
    .headData_o (fifoHead),
    .level_o    (o_q_level),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty)
  );

  always_comb begin
    headVec = '0;
    if (!fifoEmpty) headVec = fifoHead;
    else if (enq)   headVec = i_mac_rx_statvec;
  end

  assign o_head_known = ~fifoEmpty | enq;
  assign o_head_err   = |(headVec & ERR_MASK);

  // Report fields hold between packets; only the valid strobe falls back
  always_comb begin
    pktVld_d     = deq;
    pktStatvec_d = pktStatvec_q;
    pktErr_d     = pktErr_q;
    pktMiss_d    = pktMiss_q;
    if (deq) begin
      pktStatvec_d = headVec;
      pktErr_d     = o_head_err;
      pktMiss_d    = ~o_head_known;
    end
  end

  always_comb begin
    qOvf_d   = qOvf_q;
    qUnf_d   = qUnf_q;
    pktCnt_d = pktCnt_q;
    errCnt_d = errCnt_q;
    if (enq && fifoFull && !deq)   qOvf_d = 1'b1;
    if (deq && fifoEmpty && !enq)  qUnf_d = 1'b1;
    if (deq && !(&pktCnt_q))       pktCnt_d = pktCnt_q + CNT_W'(1);
    if (deq && o_head_err && !(&errCnt_q)) errCnt_d = errCnt_q + CNT_W'(1);
    if (i_cnt_clr) begin
      qOvf_d   = 1'b0;
      qUnf_d   = 1'b0;
      pktCnt_d = '0;
      errCnt_d = '0;
    end
  end

  always_ff @(posedge i_pclk or posedge i_prst) begin
    if (i_prst) begin
      staten_q     <= 1'b0;
      pktVld_q     <= 1'b0;
      pktStatvec_q <= '0;
      pktErr_q     <= 1'b0;
      pktMiss_q    <= 1'b0;
      qOvf_q       <= 1'b0;
      qUnf_q       <= 1'b0;
      pktCnt_q     <= '0;
      errCnt_q     <= '0;
    end else begin
      staten_q     <= i_mac_rx_staten;
      pktVld_q     <= pktVld_d;
      pktStatvec_q <= pktStatvec_d;
      pktErr_q     <= pktErr_d;
      pktMiss_q    <= pktMiss_d;
      qOvf_q       <= qOvf_d;
      qUnf_q       <= qUnf_d;
      pktCnt_q     <= pktCnt_d;
      errCnt_q     <= errCnt_d;
    end
  end

  assign o_pkt_stat_vld  = pktVld_q;
  assign o_pkt_statvec   = pktStatvec_q;
  assign o_pkt_err       = pktErr_q;
  assign o_pkt_stat_miss = pktMiss_q;
  assign o_q_ovf         = qOvf_q;
  assign o_q_unf         = qUnf_q;
  assign o_pkt_cnt       = pktCnt_q;
  assign o_err_cnt       = errCnt_q;

endmodule

// File: tb/tb_eth_rx_pkt_stat_q.sv
// Scoreboard bench for eth_rx_pkt_stat_q: a reference model predicts head and
// report outputs; expected reports are queued at tlast and popped one cycle later.
module tb_eth_rx_pkt_stat_q;

  localparam int STAT_W = 26;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 4;
  localparam int LVL_W  = 3;
  localparam logic [STAT_W-1:0] MASK = 26'h0020000;
  localparam logic [STAT_W-1:0] ERRV = 26'h0020000;
  localparam int CNT_MAX = 15;

  typedef struct {
    logic [STAT_W-1:0] vec;
    bit                err;
    bit                miss;
  } rep_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              staten;
  logic [STAT_W-1:0] statvec;
  logic              tvalid, tready, tlast, cntClr;
  logic              headKnown, headErr, pktVld, pktErr, pktMiss, qOvf, qUnf;
  logic [STAT_W-1:0] pktVec;
  logic [LVL_W-1:0]  qLevel;
  logic [CNT_W-1:0]  pktCnt, errCnt;

  rep_t              expQ[$];
  logic [STAT_W-1:0] mq[$];
  rep_t              lastRep;
  bit                mStatenQ, mOvf, mUnf;
  int                mPkt, mErr;
  int                vectors = 0;
  int                miscompares = 0;

  always #5 clk = ~clk;

  eth_rx_pkt_stat_q #(
    .STAT_W (STAT_W),
    .DEPTH  (DEPTH),
    .ERR_MASK (MASK),
    .CNT_W  (CNT_W)
  ) dut (
    .i_pclk           (clk),
    .i_prst           (rst),
    .i_mac_rx_staten  (staten),
    .i_mac_rx_statvec (statvec),
    .i_axis_rx_tvalid (tvalid),
    .i_axis_rx_tready (tready),
    .i_axis_rx_tlast  (tlast),
    .i_cnt_clr        (cntClr),
    .o_head_known     (headKnown),
    .o_head_err       (headErr),
    .o_pkt_stat_vld   (pktVld),
    .o_pkt_statvec    (pktVec),
    .o_pkt_err        (pktErr),
    .o_pkt_stat_miss  (pktMiss),
    .o_q_level        (qLevel),
    .o_q_ovf          (qOvf),
    .o_q_unf          (qUnf),
    .o_pkt_cnt        (pktCnt),
    .o_err_cnt        (errCnt)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    expQ.delete();
    mStatenQ = 0;
    mOvf = 0;
    mUnf = 0;
    mPkt = 0;
    mErr = 0;
    lastRep = '{vec: '0, err: 0, miss: 0};
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_known"}, 32'(headKnown), 0);
    checkOutput({tag, "_herr"},  32'(headErr), 0);
    checkOutput({tag, "_vld"},   32'(pktVld), 0);
    checkOutput({tag, "_vec"},   32'(pktVec), 0);
    checkOutput({tag, "_perr"},  32'(pktErr), 0);
    checkOutput({tag, "_miss"},  32'(pktMiss), 0);
    checkOutput({tag, "_level"}, 32'(qLevel), 0);
    checkOutput({tag, "_ovf"},   32'(qOvf), 0);
    checkOutput({tag, "_unf"},   32'(qUnf), 0);
    checkOutput({tag, "_pcnt"},  32'(pktCnt), 0);
    checkOutput({tag, "_ecnt"},  32'(errCnt), 0);
  endtask

  // One clock of stimulus; called just after a falling edge
  task automatic applyStimulus(input bit st, input logic [STAT_W-1:0] vec,
                               input bit v, input bit r, input bit l, input bit clr);
    bit                enq, deq, known, herr;
    logic [STAT_W-1:0] hvec;
    rep_t              rep;
    staten  = st;
    statvec = vec;
    tvalid  = v;
    tready  = r;
    tlast   = l;
    cntClr  = clr;
    #1;
    enq   = st & ~mStatenQ;
    deq   = v & r & l;
    known = (mq.size() != 0) || enq;
    hvec  = (mq.size() != 0) ? mq[0] : (enq ? vec : '0);
    herr  = |(hvec & MASK);
    checkOutput("head_known", 32'(headKnown), 32'(known));
    checkOutput("head_err", 32'(headErr), 32'(herr));
    if (deq) expQ.push_back('{vec: hvec, err: herr, miss: !known});

    if (enq && deq) begin
      if (mq.size() != 0) begin
        void'(mq.pop_front());
        mq.push_back(vec);
      end
    end else if (enq) begin
      if (mq.size() < DEPTH) mq.push_back(vec);
      else mOvf = 1;
    end else if (deq) begin
      if (mq.size() != 0) void'(mq.pop_front());
      else mUnf = 1;
    end
    if (deq && mPkt < CNT_MAX) mPkt++;
    if (deq && herr && mErr < CNT_MAX) mErr++;
    if (clr) begin
      mPkt = 0;
      mErr = 0;
      mOvf = 0;
      mUnf = 0;
    end
    mStatenQ = st;

    @(posedge clk);
    #1;
    checkOutput("pkt_vld", 32'(pktVld), 32'(deq));
    if (deq) begin
      if (expQ.size() == 0) begin
        checkOutput("scoreboard_empty", 32'(expQ.size()), 1);
      end else begin
        rep = expQ.pop_front();
        lastRep = rep;
      end
    end
    checkOutput("pkt_statvec", 32'(pktVec), 32'(lastRep.vec));
    checkOutput("pkt_err", 32'(pktErr), 32'(lastRep.err));
    checkOutput("pkt_miss", 32'(pktMiss), 32'(lastRep.miss));
    checkOutput("q_level", 32'(qLevel), 32'(mq.size()));
    checkOutput("q_ovf", 32'(qOvf), 32'(mOvf));
    checkOutput("q_unf", 32'(qUnf), 32'(mUnf));
    checkOutput("pkt_cnt", 32'(pktCnt), 32'(mPkt));
    checkOutput("err_cnt", 32'(errCnt), 32'(mErr));
    @(negedge clk);
  endtask

  task automatic pulseStat(input logic [STAT_W-1:0] vec);
    applyStimulus(1, vec, 0, 0, 0, 0);
    applyStimulus(0, '0, 0, 0, 0, 0);
  endtask

  task automatic sendLast();
    applyStimulus(0, '0, 1, 1, 1, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [STAT_W-1:0] rv;
    rst = 1'b1;
    staten = 0; statvec = '0; tvalid = 0; tready = 0; tlast = 0; cntClr = 0;
    modelReset();
    #1;
    checkAllZero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // Single errored packet, with staten held for three cycles as one status
    applyStimulus(1, ERRV | 26'h5, 0, 0, 0, 0);
    applyStimulus(1, ERRV | 26'h5, 0, 0, 0, 0);
    applyStimulus(1, ERRV | 26'h5, 1, 1, 0, 0);
    idle(2);
    sendLast();
    idle(1);

    // Back-to-back statuses, errors on 2nd and 4th
    pulseStat(26'h11);
    pulseStat(ERRV | 26'h22);
    pulseStat(26'h33);
    pulseStat(ERRV | 26'h44);
    for (int i = 0; i < 4; i++) sendLast();

    // Overflow then drain, then an extra tlast underflows
    for (int i = 0; i < 5; i++) pulseStat(26'h100 + STAT_W'(i) | ((i % 2) ? ERRV : '0));
    for (int i = 0; i < 4; i++) sendLast();
    sendLast();
    applyStimulus(0, '0, 0, 0, 0, 1);

    // Simultaneous enq and deq: bypass when empty, swap when full
    applyStimulus(1, ERRV | 26'h77, 1, 1, 1, 0);
    applyStimulus(0, '0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) pulseStat(26'h200 + STAT_W'(i));
    applyStimulus(1, ERRV | 26'h2ff, 1, 1, 1, 0);
    applyStimulus(0, '0, 0, 0, 0, 0);

    // tready / tvalid gating of tlast
    applyStimulus(0, '0, 1, 0, 1, 0);
    applyStimulus(0, '0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) sendLast();
    sendLast();

    // Saturation of both counters, then clear coinciding with a deq
    applyStimulus(0, '0, 0, 0, 0, 1);
    for (int i = 0; i < 18; i++) begin
      rv = STAT_W'($urandom);
      if (i < 16) rv = rv | ERRV;
      pulseStat(rv);
      sendLast();
    end
    pulseStat(ERRV);
    applyStimulus(0, '0, 1, 1, 1, 1);
    pulseStat(26'h3);
    sendLast();

    // Async reset mid-packet, no clock edge required to clear outputs
    pulseStat(ERRV | 26'h9);
    pulseStat(26'ha);
    applyStimulus(0, '0, 1, 1, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    checkAllZero("midrst");
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    sendLast();
    applyStimulus(0, '0, 0, 0, 0, 1);
    idle(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
